// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM state encoding and mode-register helper.
// Defining SDRAM_INIT_EMRS_EN adds the EMRS/TEMRS states used for mobile SDRAM.
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] P_CHARGE  = 4'b0010;
    localparam logic [3:0] AUTO_REF  = 4'b0001;
    localparam logic [3:0] NOP       = 4'b0111;
    localparam logic [3:0] M_REG_SET = 4'b0000;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRE   = 4'd1,
        ST_TRP   = 4'd2,
        ST_AR    = 4'd3,
        ST_TRF   = 4'd4,
        ST_MRS   = 4'd5,
        ST_TMRD  = 4'd6,
`ifdef SDRAM_INIT_EMRS_EN
        ST_EMRS  = 4'd7,
        ST_TEMRS = 4'd8,
`endif
        ST_END   = 4'd9
    } init_state_e;

    // Mode register word: A9 write mode, A6:A4 CAS latency, A3 burst type, A2:A0 burst length.
    function automatic logic [31:0] mode_reg_word(
        input logic [2:0] cas_lat,
        input logic [2:0] burst_len,
        input logic       burst_type,
        input logic       write_mode,
        input int         addr_w
    );
        logic [31:0] w;
        w       = '0;
        w[9]    = write_mode;
        w[6:4]  = cas_lat;
        w[3]    = burst_type;
        w[2:0]  = burst_len;
        for (int i = 0; i < 32; i++) begin
            if (i >= addr_w) begin
                w[i] = 1'b0;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter shared by all tRP/tRC/tMRD waits of the init sequencer.
// done_o is high in the last cycle of a wait that was loaded with N (N cycles total).
module sdram_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments and clear on the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: power wait, PRECHARGE ALL, AREF_NUM AUTO REFRESH, MRS,
// with soft re-init from END. Define SDRAM_INIT_EMRS_EN to append an EMRS (BA1 = 1) after MRS.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int                ADDR_W     = 13,
    parameter int                BA_W       = 2,
    parameter int                T_POWER    = 20000,
    parameter int                TRP_CLK    = 2,
    parameter int                TRC_CLK    = 7,
    parameter int                TMRD_CLK   = 3,
    parameter int                AREF_NUM   = 8,
    parameter int                CAS_LAT    = 3,
    parameter logic [2:0]        BURST_LEN  = 3'b111,
    parameter logic              BURST_TYPE = 1'b0,
    parameter logic              WRITE_MODE = 1'b0,
    parameter logic [ADDR_W-1:0] EMRS_VAL   = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_req,
    output logic [3:0]        init_cmd,
    output logic [BA_W-1:0]   init_ba,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_end,
    output logic              init_busy
);

    localparam int PWR_W = $clog2(T_POWER + 1);
    localparam int T_MAX = (TRP_CLK > TRC_CLK) ?
                           ((TRP_CLK > TMRD_CLK) ? TRP_CLK : TMRD_CLK) :
                           ((TRC_CLK > TMRD_CLK) ? TRC_CLK : TMRD_CLK);
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [ADDR_W-1:0] MR_WORD =
        ADDR_W'(mode_reg_word(3'(CAS_LAT), BURST_LEN, BURST_TYPE, WRITE_MODE, ADDR_W));

    init_state_e       state_q, state_d;
    logic [PWR_W-1:0]  pwr_q, pwr_d;
    logic [7:0]        aref_q, aref_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_done;

    logic [3:0]        cmd_q, cmd_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              end_q, end_d;
    logic              busy_q, busy_d;

`ifndef SDRAM_INIT_EMRS_EN
    // EMRS_VAL only matters when the extended mode register set is built in.
    logic unused_emrs;
    assign unused_emrs = ^EMRS_VAL;
`endif

    sdram_wait_timer #(
        .W (TMR_W)
    ) u_wait_timer (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Each command state loads the shared timer so the following wait state lasts exactly T cycles.
    always_comb begin
        state_d  = state_q;
        pwr_d    = '0;
        aref_d   = aref_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                aref_d = '0;
                pwr_d  = (pwr_q == PWR_W'(T_POWER)) ? pwr_q : pwr_q + 1'b1;
                if (pwr_q == PWR_W'(T_POWER - 1)) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TRP_CLK);
                state_d  = ST_TRP;
            end
            ST_TRP: begin
                if (tmr_done) begin
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                aref_d   = aref_q + 8'd1;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TRC_CLK);
                state_d  = ST_TRF;
            end
            ST_TRF: begin
                if (tmr_done) begin
                    state_d = (aref_q < 8'(AREF_NUM)) ? ST_AR : ST_MRS;
                end
            end
            ST_MRS: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TMRD_CLK);
                state_d  = ST_TMRD;
            end
            ST_TMRD: begin
                if (tmr_done) begin
`ifdef SDRAM_INIT_EMRS_EN
                    state_d = ST_EMRS;
`else
                    state_d = ST_END;
`endif
                end
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TMRD_CLK);
                state_d  = ST_TEMRS;
            end
            ST_TEMRS: begin
                if (tmr_done) begin
                    state_d = ST_END;
                end
            end
`endif
            ST_END: begin
                if (init_req) begin
                    aref_d  = '0;
                    state_d = ST_PRE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the current state and are registered, so they trail the state by one cycle.
    always_comb begin
        cmd_d  = NOP;
        ba_d   = '1;
        addr_d = '1;
        case (state_q)
            ST_PRE: cmd_d = P_CHARGE;
            ST_AR:  cmd_d = AUTO_REF;
            ST_MRS: begin
                cmd_d  = M_REG_SET;
                ba_d   = '0;
                addr_d = MR_WORD;
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                cmd_d          = M_REG_SET;
                ba_d           = '0;
                ba_d[BA_W-1]   = 1'b1;
                addr_d         = EMRS_VAL;
            end
`endif
            default: ;
        endcase
        end_d  = (state_q == ST_END);
        busy_d = (state_q != ST_IDLE) && (state_q != ST_END);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            pwr_q   <= '0;
            aref_q  <= '0;
            cmd_q   <= NOP;
            ba_q    <= '1;
            addr_q  <= '1;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pwr_q   <= pwr_d;
            aref_q  <= aref_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    assign init_cmd  = cmd_q;
    assign init_ba   = ba_q;
    assign init_addr = addr_q;
    assign init_end  = end_q;
    assign init_busy = busy_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three parameter sets driven with random init_req and a mid-sequence
// reset, compared every cycle against a schedule computed from the command timing rules.
module tb_sdram_init_seq;

    localparam int N = 3;
    localparam logic [3:0]  C_PRE  = 4'b0010;
    localparam logic [3:0]  C_AREF = 4'b0001;
    localparam logic [3:0]  C_NOP  = 4'b0111;
    localparam logic [3:0]  C_MRS  = 4'b0000;
    localparam logic [12:0] EMRS_V = 13'h0020;
    localparam int          A_TP   = 20000;

    typedef struct {
        int t_power; int trp; int trc; int tmrd; int aref;
        int cas; int bl; int bt; int wm;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n  [N];
    logic        req    [N];
    logic [3:0]  cmd_w  [N];
    logic [1:0]  ba_w   [N];
    logic [12:0] addr_w [N];
    logic        end_w  [N];
    logic        busy_w [N];

    cfg_t cfg    [N];
    int   edge_n [N];
    int   seq_s  [N];
    bit   pend   [N];

    int n_checks = 0;
    int n_pass   = 0;

    int a_quiet_bad = 0;
    int a_pre_e = -1, a_last_ar = -1, a_ar_n = 0, a_mrs_e = -1, a_emrs_e = -1, a_end_e = -1;
    bit a_done = 0, a_pulsed = 0, a_end_back = 0;
    int a_pulse_e = -1;
    int b_ar_n = 0, b_end_rises = 0;
    bit b_done = 0, b_end_prev = 0;
    bit c_aborted = 0;
    int c_hold = 0;

    always #5 clk = ~clk;

    sdram_init_seq #(.EMRS_VAL(EMRS_V)) u_dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n[0]), .init_req(req[0]), .init_cmd(cmd_w[0]),
        .init_ba(ba_w[0]), .init_addr(addr_w[0]), .init_end(end_w[0]), .init_busy(busy_w[0]));

    sdram_init_seq #(.T_POWER(10), .AREF_NUM(1), .CAS_LAT(2), .BURST_LEN(3'b011),
                     .EMRS_VAL(EMRS_V)) u_dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n[1]), .init_req(req[1]), .init_cmd(cmd_w[1]),
        .init_ba(ba_w[1]), .init_addr(addr_w[1]), .init_end(end_w[1]), .init_busy(busy_w[1]));

    sdram_init_seq #(.T_POWER(16), .TRP_CLK(1), .TRC_CLK(3), .TMRD_CLK(2), .AREF_NUM(5),
                     .BURST_TYPE(1'b1), .WRITE_MODE(1'b1), .EMRS_VAL(EMRS_V)) u_dut_c (
        .sys_clk(clk), .sys_rst_n(rst_n[2]), .init_req(req[2]), .init_cmd(cmd_w[2]),
        .init_ba(ba_w[2]), .init_addr(addr_w[2]), .init_end(end_w[2]), .init_busy(busy_w[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int mrs_off(cfg_t c);
        return c.trp + 1 + c.aref * (c.trc + 1);
    endfunction

    function automatic int end_off(cfg_t c);
`ifdef SDRAM_INIT_EMRS_EN
        return mrs_off(c) + 2 * (c.tmrd + 1);
`else
        return mrs_off(c) + c.tmrd + 1;
`endif
    endfunction

    // Expected {cmd, ba, addr, end, busy} at a given edge offset from the PRECHARGE edge.
    function automatic logic [20:0] expect_out(cfg_t c, int off, bit in_rst);
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        e, b;
        int          m;
        cmd = C_NOP; ba = 2'b11; addr = 13'h1FFF; e = 1'b0; b = 1'b0;
        m = mrs_off(c);
        if (!in_rst && off >= 0) begin
            if (off >= end_off(c)) begin
                e = 1'b1;
            end else begin
                b = 1'b1;
                if (off == 0) cmd = C_PRE;
                else if (off == m) begin
                    cmd = C_MRS; ba = 2'b00;
                    addr = 13'(c.wm * 512 + c.cas * 16 + c.bt * 8 + c.bl);
                end
`ifdef SDRAM_INIT_EMRS_EN
                else if (off == m + c.tmrd + 1) begin
                    cmd = C_MRS; ba = 2'b10; addr = EMRS_V;
                end
`endif
                else if (off > c.trp && off < m && (off - c.trp - 1) % (c.trc + 1) == 0)
                    cmd = C_AREF;
            end
        end
        return {cmd, ba, addr, e, b};
    endfunction

    function automatic string nm(int i);
        return (i == 0) ? "a" : (i == 1) ? "b" : "c";
    endfunction

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (!rst_n[i]) begin
                edge_n[i] = 0; seq_s[i] = cfg[i].t_power + 1; pend[i] = 0;
            end else begin
                edge_n[i]++;
                if (pend[i]) begin
                    seq_s[i] = edge_n[i]; pend[i] = 0;
                end else if (edge_n[i] - seq_s[i] >= end_off(cfg[i]) && req[i]) begin
                    pend[i] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [20:0] obs, exp;
        for (int i = 0; i < N; i++) begin
            obs = {cmd_w[i], ba_w[i], addr_w[i], end_w[i], busy_w[i]};
            exp = expect_out(cfg[i], edge_n[i] - seq_s[i], !rst_n[i]);
            if (i == 0 && rst_n[0] && edge_n[0] < A_TP - 5) begin
                if (obs !== exp) a_quiet_bad++;
            end else begin
                check($sformatf("%s_out@%0d", nm(i), edge_n[i]), obs, exp);
            end
        end
    endtask

    task automatic monitor();
        int e;
        e = edge_n[0];
        if (!a_done && rst_n[0]) begin
            case (cmd_w[0])
                C_PRE: if (a_pre_e < 0) begin
                    a_pre_e = e;
                    check("a_pre_edge", e, 20001);
                    check("a_pre_addr", addr_w[0], 13'h1FFF);
                end
                C_AREF: begin
                    if (a_ar_n == 0) check("a_ar1_gap", e - a_pre_e, 3);
                    else check("a_ar_spacing", e - a_last_ar, 8);
                    a_last_ar = e; a_ar_n++;
                end
                C_MRS: begin
                    if (a_mrs_e < 0) begin
                        a_mrs_e = e;
                        check("a_ar_count", a_ar_n, 8);
                        check("a_mrs_ba", ba_w[0], 2'b00);
                        check("a_mrs_addr", addr_w[0], 13'h0037);
                    end
`ifdef SDRAM_INIT_EMRS_EN
                    else if (a_emrs_e < 0) begin
                        a_emrs_e = e;
                        check("a_emrs_ba", ba_w[0], 2'b10);
                        check("a_emrs_addr", addr_w[0], 13'h0020);
                        check("a_emrs_gap", e - a_mrs_e, 4);
                    end
`endif
                end
                default: ;
            endcase
            if (end_w[0] && a_mrs_e >= 0) begin
`ifdef SDRAM_INIT_EMRS_EN
                check("a_end_gap", e - a_emrs_e, 4);
`else
                check("a_end_gap", e - a_mrs_e, 4);
`endif
                a_done = 1; a_end_e = e;
            end
        end
        if (a_pulsed && e == a_pulse_e + 2) begin
            check("a_reinit_pre", cmd_w[0], C_PRE);
            check("a_reinit_end_drop", end_w[0], 1'b0);
        end
        if (a_pulsed && e > a_pulse_e + 2 && end_w[0]) a_end_back = 1;
        if (!b_done && rst_n[1]) begin
            if (cmd_w[1] == C_AREF) b_ar_n++;
            if (cmd_w[1] == C_MRS) begin
                check("b_ar_count", b_ar_n, 1);
                check("b_mrs_addr", addr_w[1], 13'h0023);
                b_done = 1;
            end
        end
        if (end_w[1] && !b_end_prev) b_end_rises++;
        b_end_prev = end_w[1];
    endtask

    task automatic drive_next(input int cyc);
        req[0] = 1'b0;
        if (a_done && !a_pulsed && edge_n[0] - a_end_e >= 2) begin
            req[0] = 1'b1; a_pulsed = 1; a_pulse_e = edge_n[0];
        end
        req[1] = (cyc < 300) ? 1'b1 : ($urandom_range(0, 4) == 0);
        req[2] = ($urandom_range(0, 9) == 0);
        if (c_hold > 0) begin
            c_hold--;
            if (c_hold == 0) rst_n[2] = 1'b1;
        end else if (!c_aborted && rst_n[2] && !pend[2] && edge_n[2] - seq_s[2] == 19) begin
            #2 rst_n[2] = 1'b0;
            #1 check("c_rst_async", {cmd_w[2], ba_w[2], addr_w[2], end_w[2], busy_w[2]},
                     expect_out(cfg[2], 0, 1'b1));
            c_aborted = 1; c_hold = 2;
        end
    endtask

    initial begin
        cfg[0] = '{t_power: A_TP, trp: 2, trc: 7, tmrd: 3, aref: 8, cas: 3, bl: 7, bt: 0, wm: 0};
        cfg[1] = '{t_power: 10,   trp: 2, trc: 7, tmrd: 3, aref: 1, cas: 2, bl: 3, bt: 0, wm: 0};
        cfg[2] = '{t_power: 16,   trp: 1, trc: 3, tmrd: 2, aref: 5, cas: 3, bl: 7, bt: 1, wm: 1};
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0;
            edge_n[i] = 0; seq_s[i] = cfg[i].t_power + 1; pend[i] = 0;
        end
        repeat (3) begin
            @(posedge clk); model_edge(); #1; compare_all();
        end
        check("a_reset_cmd",  cmd_w[0],  C_NOP);
        check("a_reset_ba",   ba_w[0],   2'b11);
        check("a_reset_addr", addr_w[0], 13'h1FFF);
        check("a_reset_end",  end_w[0],  1'b0);
        check("a_reset_busy", busy_w[0], 1'b0);
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        for (int cyc = 0; cyc < 20300; cyc++) begin
            drive_next(cyc);
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
            monitor();
        end
        check("a_power_wait_quiet", a_quiet_bad, 0);
        check("a_pre_seen", a_pre_e >= 0, 1);
        check("a_first_end_seen", a_done, 1);
        check("a_reinit_pulsed", a_pulsed, 1);
        check("a_reinit_end_back", a_end_back, 1);
        check("b_mrs_seen", b_done, 1);
        check("b_held_repeats", b_end_rises >= 2, 1);
        check("c_abort_done", c_aborted, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Parametrised SDRAM power-up initialisation sequencer. It generalises the fixed-width, fixed-timing init block.
- Sequence: power-up wait, PRECHARGE ALL, AREF_NUM AUTO REFRESH commands, then MODE REGISTER SET. Address/bank widths, all timings, refresh count and mode-register fields are parameters.
- Adds a soft re-initialisation request, so the SDRAM controller can re-run the sequence (e.g. after a clock change) without a system reset.
- Sits in the SDRAM controller, ahead of the arbiter. The arbiter muxes init_cmd/init_ba/init_addr onto the bus while init_end is low.

Parameters:
- ADDR_W, 13, SDRAM address bus width; legal range ≥11.
- BA_W, 2, bank address width; legal range ≥1.
- T_POWER, 20000, power-up wait in clk cycles; legal range ≥2.
- TRP_CLK, 2, NOP cycles after PRECHARGE; legal range ≥1.
- TRC_CLK, 7, NOP cycles after each AUTO REFRESH; legal range ≥1.
- TMRD_CLK, 3, NOP cycles after MRS; legal range ≥1.
- AREF_NUM, 8, number of AUTO REFRESH commands; legal range 1..255.
- CAS_LAT, 3, mode register A6:A4; only 2 or 3 are legal.
- BURST_LEN, 3'b111, mode register A2:A0.
- BURST_TYPE, 0, mode register A3; 0 = sequential.
- WRITE_MODE, 0, mode register A9; 0 = burst write.
- EMRS_VAL, 0, extended mode register address value (ADDR_W bits); used only with the optional feature.

Ports:
- sys_clk, in, 1, clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- init_req, in, 1, re-init request; level-sampled.
- init_cmd, out, 4, {CS_n,RAS_n,CAS_n,WE_n}.
- init_ba, out, BA_W, bank address.
- init_addr, out, ADDR_W, address.
- init_end, out, 1, high while the sequence is complete.
- init_busy, out, 1, high while a PRE..MRS sequence or its waits are in progress.

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is asynchronous and active-low (sys_rst_n); all flops clear immediately on assertion.
- Reset values:
  - init_cmd = NOP (4'b0111)
  - init_ba = all ones
  - init_addr = all ones
  - init_end = 0
  - init_busy = 0
  - state = IDLE
  - all counters = 0
- Command encodings: PRECHARGE = 4'b0010, AUTO_REF = 4'b0001, NOP = 4'b0111, MRS = 4'b0000.
- Output timing: outputs are registered from state, so each command appears on init_cmd one cycle after its issuing state is entered.
- Idle (power-up wait) state:
  - Power counter, width $clog2(T_POWER+1), saturates at T_POWER.
  - Leave IDLE when the counter equals T_POWER-1.
  - The first PRECHARGE appears on init_cmd at edge T_POWER+1 after reset release.
- States and transitions:
  - IDLE → PRE → TRP → AR → TRF → (AR again if aref_cnt < AREF_NUM, else MRS) → TMRD → END.
- Command states (PRE, AR, MRS) last exactly 1 cycle.
- Wait states (TRP, TRF, TMRD):
  - Each lasts exactly TRP_CLK, TRC_CLK or TMRD_CLK cycles respectively.
  - A shared down-counter is loaded on entry to the wait state.
  - Consecutive non-NOP commands are therefore T+1 clks apart.
- Command contents:
  - PRE: ba all ones, addr all ones (A10 = 1, all banks).
  - AR: ba and addr all ones.
  - MRS: ba = 0; addr = zero-extended {WRITE_MODE, 2'b00, CAS_LAT[2:0], BURST_TYPE, BURST_LEN}.
  - All other states: NOP, ba and addr all ones.
- aref_cnt (8 bits):
  - Cleared in IDLE and on re-init entry.
  - Incremented once per AR cycle.
  - Exactly AREF_NUM AUTO_REF commands are issued.
- Status outputs:
  - init_end = (state == END).
  - init_busy = 1 in every state except IDLE and END.
- Re-init from END:
  - init_req = 1 in END moves to PRE next cycle, skipping the power wait.
  - init_end falls on that same edge.
- init_req is ignored in all other states; no queuing.
- A held init_req causes back-to-back sequences. Each sequence still ends with at least one END cycle showing init_end = 1.
- Reset mid-sequence: abort immediately; the full T_POWER wait reruns after release.
- Undefined state encodings go to IDLE.

Optional Feature:
- Macro: SDRAM_INIT_EMRS_EN.
- When defined: TMRD → EMRS → TEMRS (TMRD_CLK cycles) → END.
  - EMRS issues MRS with ba = {1'b1, zeros} (BA1 = 1) and addr = EMRS_VAL.
  - This extended mode register set is for mobile SDRAM.
- When undefined: TMRD → END directly; EMRS_VAL is unused and the EMRS/TEMRS states do not exist.

Decomposition:
- Package sdram_pkg contains:
  - command encodings (P_CHARGE, AUTO_REF, NOP, M_REG_SET);
  - init state encoding;
  - a function building the mode-register word from CAS_LAT, BURST_LEN, BURST_TYPE, WRITE_MODE and ADDR_W.
- Sub-module sdram_wait_timer: loadable down-counter with load value, load strobe and done flag, reused for all tRP/tRC/tMRD waits.

Test Plan:
- Defaults, reset release:
  - PRECHARGE at cycle 20001 with addr = 13'h1FFF.
  - AUTO_REF 3 cycles later.
  - 8 AUTO_REFs spaced 8 cycles apart.
  - MRS with ba = 0, addr = 13'h0037.
  - init_end high 4 cycles after MRS.
- Parameters T_POWER = 10, AREF_NUM = 1, CAS_LAT = 2, BURST_LEN = 3'b011:
  - Exactly one AUTO_REF.
  - MRS addr = 13'h0023.
- init_req pulse in END:
  - init_end drops next edge.
  - PRECHARGE appears 2 cycles after the pulse, with no power wait.
  - Full sequence reruns and init_end returns.
- init_req held high from reset: ignored until END, then sequences repeat, each with ≥1 init_end cycle.
- sys_rst_n asserted during the 5th TRF:
  - Outputs go to NOP / all ones immediately.
  - After release, the full T_POWER wait reruns and aref_cnt restarts at 0.
- With SDRAM_INIT_EMRS_EN and EMRS_VAL = 13'h0020:
  - Second MRS appears with ba = 2'b10, addr = 13'h0020, TMRD_CLK+1 cycles after the first.
  - init_end follows TMRD_CLK+1 cycles later.
